// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA timing receiver.
package vga_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        MEASURE  = 2'd1,
        LOCKED   = 2'd2
    } rx_state_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    // True when a raw sync level equals its asserted polarity.
    function automatic logic sync_active(input logic lvl, input logic pol);
        return (lvl == pol);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop capture of one timing input, normalised so 1 means "asserted",
// with assertion/deassertion edge pulses derived from the two stages.
module vga_sync_edge
    import vga_pkg::*;
#(
    parameter bit POL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic level_o,
    output logic assert_o,
    output logic deassert_o
);

    logic s1_r;
    logic s2_r;

    // Normalise polarity at capture and keep one cycle of history for edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= sync_active(sig_i, POL);
            s2_r <= s1_r;
        end
    end

    assign level_o    = s1_r;
    assign assert_o   = s1_r & ~s2_r;
    assign deassert_o = ~s1_r & s2_r;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers pixel coordinates from hs/vs/de, checks
// line and frame geometry, and declares lock after LOCK_FRAMES clean frames.
// Optional build macro VGA_RX_ERRCNT_EN adds a saturating 16-bit err_cnt_o.
// H_ACTIVE is expected to be below 2^CW so a saturated column cannot alias it.
module vga_timing_rx
    import vga_pkg::*;
#(
    parameter int CW          = 10,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES = 2,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          hs_i,
    input  logic          vs_i,
    input  logic          de_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          pix_valid_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic          locked_o,
`ifdef VGA_RX_ERRCNT_EN
    output logic [15:0]   err_cnt_o,
`endif
    output logic          err_o
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   H_ACT_C = H_ACTIVE[CW:0];
    localparam logic [CW:0]   V_ACT_C = V_ACTIVE[CW:0];
    localparam logic [3:0]    LOCK_C  = LOCK_FRAMES[3:0];

    logic hs_lvl_s, hs_rise_s, hs_fall_s;
    logic vs_lvl_s, vs_rise_s, vs_fall_s;
    logic de_lvl_s, de_rise_s, de_fall_s;
    logic unused_s;

    vga_sync_edge #(.POL(HS_POL != 0)) u_hs (
        .clk_i(clk_i), .rst_ni(rst_ni), .sig_i(hs_i),
        .level_o(hs_lvl_s), .assert_o(hs_rise_s), .deassert_o(hs_fall_s)
    );
    vga_sync_edge #(.POL(VS_POL != 0)) u_vs (
        .clk_i(clk_i), .rst_ni(rst_ni), .sig_i(vs_i),
        .level_o(vs_lvl_s), .assert_o(vs_rise_s), .deassert_o(vs_fall_s)
    );
    vga_sync_edge #(.POL(1'b1)) u_de (
        .clk_i(clk_i), .rst_ni(rst_ni), .sig_i(de_i),
        .level_o(de_lvl_s), .assert_o(de_rise_s), .deassert_o(de_fall_s)
    );

    assign unused_s = hs_lvl_s ^ hs_fall_s ^ vs_fall_s;

    rx_state_t     state_r;
    logic [3:0]    good_cnt_r;
    logic [3:0]    good_inc_s;
    logic [CW-1:0] x_cnt_r, x_nxt_s;
    logic [CW-1:0] y_cnt_r, y_nxt_s;
    logic [CW:0]   x_len_s;
    logic          line_open_r, line_open_nxt_s;
    logic          dv_flag_r, dv_flag_nxt_s;
    logic          dirty_r, dirty_nxt_s;
    logic          err_line_s, err_short_s, err_frame_s, err_dvs_s, err_s;

    // Pixels seen in the current de run (last column index + 1).
    assign x_len_s    = {1'b0, x_cnt_r} + {{CW{1'b0}}, 1'b1};
    assign good_inc_s = good_cnt_r + 4'd1;

    // Only lines opened by a de rise (and not cut by vs) are length-checked.
    assign err_line_s  = de_fall_s & line_open_r & (x_len_s != H_ACT_C);
    assign err_short_s = vs_rise_s & de_lvl_s;
    assign err_frame_s = vs_rise_s & (state_r != UNLOCKED) & ({1'b0, y_cnt_r} != V_ACT_C);
    assign err_dvs_s   = de_lvl_s & vs_lvl_s & ~dv_flag_r;
    assign err_s       = err_line_s | err_short_s | err_frame_s | err_dvs_s;

    // Next-state of the coordinate counters and per-line/per-frame flags.
    always_comb begin
        x_nxt_s         = x_cnt_r;
        y_nxt_s         = y_cnt_r;
        line_open_nxt_s = line_open_r;
        dv_flag_nxt_s   = 1'b0;
        dirty_nxt_s     = dirty_r;

        if (de_lvl_s) begin
            if (de_rise_s) begin
                x_nxt_s = {CW{1'b0}};
            end else if (x_cnt_r != CNT_MAX) begin
                x_nxt_s = x_cnt_r + ONE_C;
            end else begin
                x_nxt_s = x_cnt_r;
            end
            dv_flag_nxt_s = dv_flag_r | vs_lvl_s;
        end else begin
            x_nxt_s       = x_cnt_r;
            dv_flag_nxt_s = 1'b0;
        end

        // Frame start wins over any line bookkeeping in the same cycle.
        if (vs_rise_s) begin
            y_nxt_s = {CW{1'b0}};
        end else if (de_fall_s && line_open_r && (y_cnt_r != CNT_MAX)) begin
            y_nxt_s = y_cnt_r + ONE_C;
        end else begin
            y_nxt_s = y_cnt_r;
        end

        if (vs_rise_s) begin
            line_open_nxt_s = 1'b0;
        end else if (de_rise_s) begin
            line_open_nxt_s = 1'b1;
        end else if (de_fall_s) begin
            line_open_nxt_s = 1'b0;
        end else begin
            line_open_nxt_s = line_open_r;
        end

        // An error anywhere in a frame disqualifies it from the clean count.
        if (vs_rise_s) begin
            dirty_nxt_s = 1'b0;
        end else begin
            dirty_nxt_s = dirty_r | err_s;
        end
    end

    // Coordinate counters and bookkeeping flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_cnt_r     <= {CW{1'b0}};
            y_cnt_r     <= {CW{1'b0}};
            line_open_r <= 1'b0;
            dv_flag_r   <= 1'b0;
            dirty_r     <= 1'b0;
        end else begin
            x_cnt_r     <= x_nxt_s;
            y_cnt_r     <= y_nxt_s;
            line_open_r <= line_open_nxt_s;
            dv_flag_r   <= dv_flag_nxt_s;
            dirty_r     <= dirty_nxt_s;
        end
    end

    // Lock FSM: counts clean frames in MEASURE, any error falls back to MEASURE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= UNLOCKED;
            good_cnt_r <= 4'd0;
            locked_o   <= 1'b0;
        end else begin
            case (state_r)
                UNLOCKED: begin
                    locked_o <= 1'b0;
                    if (vs_rise_s) begin
                        state_r    <= MEASURE;
                        good_cnt_r <= 4'd0;
                    end else begin
                        state_r <= UNLOCKED;
                    end
                end
                MEASURE: begin
                    if (err_s) begin
                        good_cnt_r <= 4'd0;
                        locked_o   <= 1'b0;
                    end else if (vs_rise_s && !dirty_r) begin
                        good_cnt_r <= good_inc_s;
                        if (good_inc_s == LOCK_C) begin
                            state_r  <= LOCKED;
                            locked_o <= 1'b1;
                        end else begin
                            locked_o <= 1'b0;
                        end
                    end else begin
                        locked_o <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (err_s) begin
                        state_r    <= MEASURE;
                        good_cnt_r <= 4'd0;
                        locked_o   <= 1'b0;
                    end else begin
                        locked_o <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= UNLOCKED;
                    good_cnt_r <= 4'd0;
                    locked_o   <= 1'b0;
                end
            endcase
        end
    end

    // Registered pixel/pulse outputs; coordinates hold outside active video.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_o           <= {CW{1'b0}};
            y_o           <= {CW{1'b0}};
            pix_valid_o   <= 1'b0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            pix_valid_o   <= de_lvl_s;
            line_start_o  <= hs_rise_s;
            frame_start_o <= vs_rise_s;
            err_o         <= err_s;
            if (de_lvl_s) begin
                x_o <= x_nxt_s;
                y_o <= y_cnt_r;
            end else begin
                x_o <= x_o;
                y_o <= y_o;
            end
        end
    end

`ifdef VGA_RX_ERRCNT_EN
    // Saturating count of err_o pulses; only a hard reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= 16'd0;
        end else if (err_s && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end else begin
            err_cnt_o <= err_cnt_o;
        end
    end
`endif

endmodule
